seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Receive-side counterpart of the multiplexed seven-segment driver: watches the 12-bit display bus (active-low one-hot digit select plus 8 segment lines), waits for each digit window to settle, and rebuilds the full `8*NUMCELLS`-bit cell image. It sits on the FPGA side of a board-level loopback or probe header. It feeds self-test logic and lets a design read back the contents of a physical display.

## Interface
- `NUMCELLS`, 4: number of digits; select width.
- `SETTLE`, 16: consecutive stable clock cycles required before a segment byte is sampled; minimum 1.
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `sig`, in, `NUMCELLS+8`: display bus, packed `{sel, seg}`.
  - `sel` is active-low one-hot.
  - `seg[0]` = segment A … `seg[6]` = G, `seg[7]` = DP.
  - The bus is asynchronous to `clock`.
- `cellvalout`, out, `8*NUMCELLS`: last complete frame. Byte k (`[8k+7:8k]`) holds the segments captured while `sel[k]` was low.
- `frame_done`, out, 1: one-cycle pulse in the cycle `cellvalout` updates.
- `sel_err`, out, 1: one-cycle pulse on entry to an illegal select pattern.
- `cap_mask`, out, `NUMCELLS`: cells captured so far in the current frame. Debug only.

## Operation
- `sig` passes through a 2-flop synchronizer. All logic below uses the synchronized value `s_sig` and the previous cycle's value `p_sig`.
- Select classification:
  - Legal: exactly one bit low.
  - Blank: all bits high. Ignored, no error.
  - Illegal: anything else. `sel_err` pulses on the first cycle of an illegal pattern; the FSM goes to WAIT.
- FSM states and transitions:
  - WAIT: wait for a legal select.
    - When `s_sig` is legal: clear the stability counter and go to SETTLE.
  - SETTLE: count stable cycles.
    - If `s_sig != p_sig`: go back to WAIT. The counter clears because the select may also have changed.
    - Otherwise the counter increments.
    - When the counter reaches `SETTLE-1` with the bus stable: capture the segment byte into shadow byte k, set `cap_mask[k]`, go to HOLD.
  - HOLD: at most one capture per select window.
    - Any change in the select bits goes to WAIT.
    - Changes in segment bits only are ignored.
- Frame completion: in the cycle a capture sets the final mask bit (mask would become all-ones), the following happen together:
  - the shadow, including the byte just captured, is copied into `cellvalout`;
  - `frame_done` pulses;
  - the mask clears.
- Recapturing cell k before the frame completes overwrites shadow byte k. The mask is unchanged.
- The counter width is `$clog2(SETTLE+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - `cellvalout` = 0, shadow = 0, `cap_mask` = 0;
  - `frame_done` = 0, `sel_err` = 0;
  - FSM in WAIT, synchronizer flops = all-ones (blank).
- `reset` may assert mid-frame. The partial frame is discarded and the previous `cellvalout` is cleared to 0.
- Latency: from a `sig` edge to the capture is 2 sync cycles + 1 cycle to enter SETTLE + `SETTLE` cycles.
  - `frame_done` and the `cellvalout` update appear in the same cycle as the final capture, and are registered.
- A glitch shorter than `SETTLE` cycles never causes a capture.
- Simultaneous change of sel and seg counts as one change.
- An illegal pattern arriving during SETTLE or HOLD aborts that window. No capture happens.

## Structure
- Shared package/include `seven_seg_pkg` holds:
  - segment bit indices `SEG_A`…`SEG_G`, `SEG_DP`;
  - the bus packing macro/function `{sel, seg}`.
  The driver and this block both use it.
- Sub-module `seg_bus_sync`: parameterised-width 2-flop synchronizer with a reset value parameter (all-ones here).
- Everything else is in one module: FSM, counter, shadow, mask.

## Test plan
All scenarios use `NUMCELLS=4`, `SETTLE=4`.
- **Clean scan:** drive sel `1110/1101/1011/0111` with seg `0x3F/0x06/0x5B/0x4F`, each for 20 cycles -> one `frame_done` pulse; `cellvalout = 0x4F5B063F`.
- **Glitch filter:** while in window sel=`1110`, flip seg to `0xFF` for 2 cycles, then hold `0x3F` for 10 cycles -> byte 0 = `0x3F`, never `0xFF`.
- **Blank and illegal:** insert `1111` between windows -> no `sel_err`, frame still completes. Drive `1100` -> exactly one `sel_err` pulse, no capture, mask unchanged.
- **Out-of-order and repeat:**
  - Order cells 2,0,0,3,1 with seg values `0x11, 0x22, 0x33, 0x44, 0x55`.
  - Expect `frame_done` after cell 1, with `cellvalout = 0x44115533` (byte 0 overwritten by `0x33`, the repeat).
- **Reset mid-frame:** assert `reset` after 2 captures -> all outputs 0. A subsequent full scan yields exactly one `frame_done` with the new values.
- **Segment change in HOLD:** after the capture of `0x06`, change seg to `0x7F` without changing sel -> byte stays `0x06`.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared definitions for the seven-segment display bus, used by both the
// multiplexed driver and the capture block.
//   - SEG_A..SEG_G, SEG_DP : bit positions of each segment within seg[7:0]
//   - `SEVEN_SEG_PACK      : builds the bus word {sel, seg}
//   - sel_class_t          : classification of a select pattern
//   - cap_state_t          : capture FSM states
//   - classify_sel()       : classifies an active-low select, padded with ones

`define SEVEN_SEG_PACK(sel, seg) {(sel), (seg)}

package seven_seg_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef enum logic [1:0] {
    SEL_BLANK,
    SEL_LEGAL,
    SEL_ILLEGAL
  } sel_class_t;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_SETTLE,
    ST_HOLD
  } cap_state_t;

  // Callers pad unused upper bits with ones, so only real select lines can
  // count as low.
  function automatic sel_class_t classify_sel(input logic [31:0] sel_pad);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 32; i++) begin
      if (!sel_pad[i]) zeros++;
    end
    if (zeros == 0) return SEL_BLANK;
    if (zeros == 1) return SEL_LEGAL;
    return SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if
// Groups the display bus and the capture results.
//   sig        : display bus {sel, seg}, sel active-low one-hot
//   cellvalout : last complete frame, byte k = segments seen while sel[k] low
//   frame_done : one-cycle pulse when cellvalout updates
//   sel_err    : one-cycle pulse on entry to an illegal select pattern
//   cap_mask   : cells captured so far in the current frame (debug)
// master = display / stimulus side, slave = capture block.

interface seven_seg_capture_if #(
  parameter int NUMCELLS = 4
);
  logic [NUMCELLS+7:0]   sig;
  logic [8*NUMCELLS-1:0] cellvalout;
  logic                  frame_done;
  logic                  sel_err;
  logic [NUMCELLS-1:0]   cap_mask;

  modport master (
    output sig,
    input  cellvalout, frame_done, sel_err, cap_mask
  );

  modport slave (
    input  sig,
    output cellvalout, frame_done, sel_err, cap_mask
  );
endinterface

// File: rtl/seg_bus_sync.sv
// seg_bus_sync
// Two-flop synchronizer for a multi-bit bus asynchronous to clock.
//   clock : sampling clock
//   reset : asynchronous active-high reset, loads RESET_VAL into both flops
//   d     : asynchronous input bus
//   q     : synchronized output bus
// Bits are synchronized independently; the consumer must tolerate
// momentary mixed old/new words (the capture block does, via its settle
// counter).

module seg_bus_sync #(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
// Watches a multiplexed seven-segment bus and rebuilds the full cell image.
//   clock : sole clock
//   reset : asynchronous active-high reset
//   bus   : seven_seg_capture_if.slave
//           sig in; cellvalout, frame_done, sel_err, cap_mask out
// Each digit window must hold the bus stable for SETTLE cycles before its
// segment byte is taken. When the last missing cell is captured, the shadow
// image (including that byte) is published on cellvalout.

module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int NUMCELLS = 4,
  parameter int SETTLE   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  seven_seg_capture_if.slave   bus
);

  localparam int W  = NUMCELLS + 8;
  localparam int CW = $clog2(SETTLE + 1);

  logic [W-1:0]          s_sig;
  logic [W-1:0]          p_sig;
  logic [NUMCELLS-1:0]   s_sel;
  logic [NUMCELLS-1:0]   p_sel;
  logic [7:0]            s_seg;
  sel_class_t            sel_cls;
  logic                  bus_changed;
  logic                  sel_changed;

  cap_state_t            state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [8*NUMCELLS-1:0] shadow_reg;
  logic [8*NUMCELLS-1:0] shadow_next;
  logic [8*NUMCELLS-1:0] cellval_reg;
  logic [NUMCELLS-1:0]   mask_reg;
  logic [NUMCELLS-1:0]   mask_next;
  logic                  frame_done_reg;
  logic                  sel_err_reg;

  seg_bus_sync #(
    .WIDTH     (W),
    .RESET_VAL ({W{1'b1}})
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.sig),
    .q     (s_sig)
  );

  assign s_sel       = s_sig[W-1:8];
  assign p_sel       = p_sig[W-1:8];
  assign s_seg       = s_sig[7:0];
  assign sel_cls     = classify_sel({{(32-NUMCELLS){1'b1}}, s_sel});
  assign bus_changed = (s_sig != p_sig);
  assign sel_changed = (s_sel != p_sel);

  // The captured cell is the one whose select line is low; only meaningful
  // in SETTLE, where the select is known to be legal.
  assign mask_next = mask_reg | ~s_sel;

  for (genvar gi = 0; gi < NUMCELLS; gi++) begin : g_shadow
    assign shadow_next[8*gi +: 8] = s_sel[gi] ? shadow_reg[8*gi +: 8] : s_seg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_sig          <= '1;
      state_reg      <= ST_WAIT;
      cnt_reg        <= '0;
      shadow_reg     <= '0;
      cellval_reg    <= '0;
      mask_reg       <= '0;
      frame_done_reg <= 1'b0;
      sel_err_reg    <= 1'b0;
    end else begin
      p_sig          <= s_sig;
      frame_done_reg <= 1'b0;
      // A held illegal pattern matches the previous cycle, so this fires once.
      sel_err_reg    <= (sel_cls == SEL_ILLEGAL) && sel_changed;

      case (state_reg)
        ST_WAIT: begin
          if (sel_cls == SEL_LEGAL) begin
            cnt_reg   <= '0;
            state_reg <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (bus_changed) begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT;
          end else if (cnt_reg == CW'(SETTLE - 1)) begin
            shadow_reg <= shadow_next;
            state_reg  <= ST_HOLD;
            if (&mask_next) begin
              cellval_reg    <= shadow_next;
              frame_done_reg <= 1'b1;
              mask_reg       <= '0;
            end else begin
              mask_reg <= mask_next;
            end
          end else if (cnt_reg != CW'(SETTLE)) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_HOLD: begin
          // Segment-only changes are ignored: one capture per select window.
          if (sel_changed) begin
            state_reg <= ST_WAIT;
          end
        end

        default: state_reg <= ST_WAIT;
      endcase
    end
  end

  assign bus.cellvalout = cellval_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.sel_err    = sel_err_reg;
  assign bus.cap_mask   = mask_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture
// Scoreboard bench: each scan pushes its expected frame; a monitor pops and
// compares on every frame_done pulse.

module tb_seven_seg_capture;

  localparam int NC = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  seven_seg_capture_if #(.NUMCELLS(NC)) bus ();

  seven_seg_capture #(.NUMCELLS(NC), .SETTLE(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int frame_count = 0;
  int err_count   = 0;
  logic [31:0] exp_q[$];

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (bus.sel_err === 1'b1) err_count++;
    if (bus.frame_done === 1'b1) begin
      logic [31:0] exp_v;
      frame_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame_unexpected: got cellvalout=%08h, required no frame", bus.cellvalout);
      end else begin
        exp_v = exp_q.pop_front();
        if (bus.cellvalout !== exp_v) begin
          bad++;
          $display("FAIL frame_value: got %08h, required %08h", bus.cellvalout, exp_v);
        end else begin
          $display("frame ok: cellvalout=%08h", bus.cellvalout);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] sel, input logic [7:0] seg, input int n);
    @(posedge clock);
    #1 bus.sig = {sel, seg};
    repeat (n) @(posedge clock);
  endtask

  function automatic logic [3:0] sel_of(input int k);
    logic [3:0] s;
    s = 4'b1111;
    s[k] = 1'b0;
    return s;
  endfunction

  task automatic std_scan(input logic [31:0] v, input int blank_gap);
    for (int k = 0; k < NC; k++) begin
      drive(sel_of(k), v[8*k +: 8], 20);
      if (blank_gap > 0) drive(4'b1111, 8'h00, blank_gap);
    end
    drive(4'b1111, 8'h00, 6);
  endtask

  task automatic test_reset;
    bus.sig = '1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (bus.cellvalout !== 32'h0) begin bad++; $display("FAIL reset_cellval: got %08h, required 0", bus.cellvalout); end
    total++; if (bus.cap_mask !== 4'h0) begin bad++; $display("FAIL reset_mask: got %h, required 0", bus.cap_mask); end
    total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done); end
    total++; if (bus.sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err: got %b, required 0", bus.sel_err); end
    $display("reset checked");
    reset = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_clean_scan;
    int f0;
    f0 = frame_count;
    exp_q.push_back(32'h4F5B063F);
    drive(4'b1110, 8'h3F, 20);
    @(negedge clock);
    total++; if (bus.cap_mask !== 4'b0001) begin bad++; $display("FAIL clean_mask: got %b, required 0001", bus.cap_mask); end
    drive(4'b1101, 8'h06, 20);
    drive(4'b1011, 8'h5B, 20);
    drive(4'b0111, 8'h4F, 20);
    drive(4'b1111, 8'h00, 6);
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL clean_frames: got %0d, required 1", frame_count - f0); end
    total++; if (bus.cap_mask !== 4'b0000) begin bad++; $display("FAIL clean_mask_clear: got %b, required 0000", bus.cap_mask); end
    $display("clean scan done");
  endtask

  task automatic test_glitch;
    int f0;
    f0 = frame_count;
    exp_q.push_back(32'h4F5B063F);
    drive(4'b1110, 8'h3F, 2);
    drive(4'b1110, 8'hFF, 2);
    drive(4'b1110, 8'h3F, 10);
    drive(4'b1101, 8'h06, 20);
    drive(4'b1011, 8'h5B, 20);
    drive(4'b0111, 8'h4F, 20);
    drive(4'b1111, 8'h00, 6);
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL glitch_frames: got %0d, required 1", frame_count - f0); end
    $display("glitch filter done");
  endtask

  task automatic test_blank_illegal;
    int f0, e0;
    f0 = frame_count;
    e0 = err_count;
    exp_q.push_back(32'h4F5B063F);
    std_scan(32'h4F5B063F, 5);
    total++; if (err_count - e0 !== 0) begin bad++; $display("FAIL blank_sel_err: got %0d pulses, required 0", err_count - e0); end
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL blank_frames: got %0d, required 1", frame_count - f0); end
    f0 = frame_count;
    exp_q.push_back(32'h4F5B063F);
    drive(4'b1110, 8'h3F, 20);
    drive(4'b1100, 8'h12, 20);
    @(negedge clock);
    total++; if (err_count - e0 !== 1) begin bad++; $display("FAIL illegal_sel_err: got %0d pulses, required 1", err_count - e0); end
    total++; if (bus.cap_mask !== 4'b0001) begin bad++; $display("FAIL illegal_mask: got %b, required 0001", bus.cap_mask); end
    drive(4'b1101, 8'h06, 20);
    drive(4'b1011, 8'h5B, 20);
    drive(4'b0111, 8'h4F, 20);
    drive(4'b1111, 8'h00, 6);
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL illegal_frames: got %0d, required 1", frame_count - f0); end
    $display("blank and illegal done");
  endtask

  task automatic test_out_of_order;
    int f0;
    int order [5] = '{2, 0, 0, 3, 1};
    logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    f0 = frame_count;
    exp_q.push_back(32'h44115533);
    for (int i = 0; i < 5; i++) begin
      drive(sel_of(order[i]), vals[i], 20);
      drive(4'b1111, 8'h00, 5);
      if (i == 3) begin
        total++; if (frame_count - f0 !== 0) begin bad++; $display("FAIL ooo_early_frame: got %0d, required 0", frame_count - f0); end
        total++; if (bus.cap_mask !== 4'b1101) begin bad++; $display("FAIL ooo_mask: got %b, required 1101", bus.cap_mask); end
      end
    end
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL ooo_frames: got %0d, required 1", frame_count - f0); end
    $display("out-of-order done");
  endtask

  task automatic test_reset_mid;
    int f0;
    drive(4'b1110, 8'hAA, 20);
    drive(4'b1101, 8'hBB, 20);
    @(negedge clock);
    total++; if (bus.cap_mask !== 4'b0011) begin bad++; $display("FAIL mid_mask: got %b, required 0011", bus.cap_mask); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total++; if (bus.cellvalout !== 32'h0) begin bad++; $display("FAIL mid_cellval: got %08h, required 0", bus.cellvalout); end
    total++; if (bus.cap_mask !== 4'h0) begin bad++; $display("FAIL mid_reset_mask: got %b, required 0", bus.cap_mask); end
    reset = 1'b0;
    drive(4'b1111, 8'h00, 4);
    f0 = frame_count;
    exp_q.push_back(32'h0D0C0B0A);
    std_scan(32'h0D0C0B0A, 0);
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL mid_frames: got %0d, required 1", frame_count - f0); end
    $display("reset mid-frame done");
  endtask

  task automatic test_hold_seg_change;
    int f0;
    f0 = frame_count;
    exp_q.push_back(32'h4F5B063F);
    drive(4'b1110, 8'h3F, 20);
    drive(4'b1101, 8'h06, 10);
    drive(4'b1101, 8'h7F, 10);
    drive(4'b1011, 8'h5B, 20);
    drive(4'b0111, 8'h4F, 20);
    drive(4'b1111, 8'h00, 6);
    total++; if (frame_count - f0 !== 1) begin bad++; $display("FAIL hold_frames: got %0d, required 1", frame_count - f0); end
    $display("hold seg change done");
  endtask

  initial begin
    bus.sig = '1;
    test_reset();
    test_clean_scan();
    test_glitch();
    test_blank_illegal();
    test_out_of_order();
    test_reset_mid();
    test_hold_seg_change();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d frames outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
